// File: rtl/keypad_entry.sv
`timescale 1ns/1ps
// keypad_entry: scans a 4x3 keypad, debounces whole-keypad snapshots and assembles
// digit presses into a 4-digit BCD MMSS preset for the countdown clock.
//
// Ports:
//   gclk      - system clock
//   rst_n     - asynchronous active-low reset
//   keypadc   - column sense, active-high, col0..col2 left to right
//   keypadr   - one-hot active-high row drive, row0 on top
//   preset    - BCD {M10,M1,S10,S1} entry
//   load      - one-cycle pulse: preset accepted by '#'
//   key_valid - one-cycle pulse per accepted key press
//   key_code  - code of the last accepted key (0-9, A='*', B='#')
//   entry_err - one-cycle pulse: '#' rejected, tens digit of MM or SS above 5
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 4000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        gclk,
  input  logic        rst_n,
  input  logic [2:0]  keypadc,
  output logic [3:0]  keypadr,
  output logic [15:0] preset,
  output logic        load,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        entry_err
);

  localparam int unsigned CntW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MatchW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [3:0] KeyNone  = 4'hE;
  localparam logic [3:0] KeyMulti = 4'hF;
  localparam logic [3:0] KeyStar  = 4'hA;
  localparam logic [3:0] KeyHash  = 4'hB;

  // Snapshot bit index is row*3 + col.
  function automatic logic [3:0] key_of(input int idx);
    logic [3:0] k;
    case (idx)
      9:       k = KeyStar;
      10:      k = 4'h0;
      11:      k = KeyHash;
      default: k = 4'(idx + 1);
    endcase
    return k;
  endfunction

  logic [CntW-1:0]   slot_q;
  logic [1:0]        row_q;
  logic [8:0]        samp_q;       // rows 0..2; row3 is taken live at scan completion
  logic [3:0]        cand_q, stable_q;
  logic [MatchW-1:0] match_q;
  logic [15:0]       preset_q;
  logic              load_q, key_valid_q, entry_err_q;
  logic [3:0]        key_code_q;

  logic              slot_last, scan_done, evt;
  logic [11:0]       snap;
  logic [3:0]        ones, hit, raw;
  logic [3:0]        cand_d, stable_d;
  logic [MatchW-1:0] match_d;

  always_comb begin
    slot_last = (slot_q == CntW'(SCAN_DIV - 1));
    scan_done = slot_last && (row_q == 2'd3);
    snap      = {keypadc, samp_q};

    ones = '0;
    hit  = KeyNone;
    for (int i = 0; i < 12; i++) begin
      if (snap[i]) begin
        ones = ones + 4'd1;
        hit  = key_of(i);
      end
    end
    if (ones == 4'd0)      raw = KeyNone;
    else if (ones == 4'd1) raw = hit;
    else                   raw = KeyMulti;

    cand_d   = cand_q;
    match_d  = match_q;
    stable_d = stable_q;
    if (scan_done) begin
      if (raw == cand_q) begin
        if (match_q < MatchW'(DEBOUNCE_SCANS)) match_d = match_q + MatchW'(1);
      end else begin
        cand_d  = raw;
        match_d = MatchW'(1);
      end
      if (match_d == MatchW'(DEBOUNCE_SCANS)) stable_d = cand_d;
    end

    // Only a NONE -> key transition is an event; MULTI blocks rollover presses.
    evt = scan_done && (stable_q == KeyNone) && (stable_d <= KeyHash);
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      row_q       <= '0;
      samp_q      <= '0;
      cand_q      <= KeyNone;
      match_q     <= '0;
      stable_q    <= KeyNone;
      preset_q    <= '0;
      load_q      <= 1'b0;
      key_valid_q <= 1'b0;
      entry_err_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      load_q      <= 1'b0;
      key_valid_q <= 1'b0;
      entry_err_q <= 1'b0;
      cand_q      <= cand_d;
      match_q     <= match_d;
      stable_q    <= stable_d;

      if (slot_last) begin
        slot_q <= '0;
        row_q  <= row_q + 2'd1;
        case (row_q)
          2'd0:    samp_q[2:0] <= keypadc;
          2'd1:    samp_q[5:3] <= keypadc;
          2'd2:    samp_q[8:6] <= keypadc;
          default: ;
        endcase
      end else begin
        slot_q <= slot_q + CntW'(1);
      end

      if (evt) begin
        key_valid_q <= 1'b1;
        key_code_q  <= stable_d;
        if (stable_d == KeyStar) begin
          preset_q <= '0;
        end else if (stable_d == KeyHash) begin
          if (preset_q[7:4] <= 4'd5 && preset_q[15:12] <= 4'd5) load_q      <= 1'b1;
          else                                                  entry_err_q <= 1'b1;
        end else begin
          preset_q <= {preset_q[11:0], stable_d};
        end
      end
    end
  end

  assign keypadr   = 4'b0001 << row_q;
  assign preset    = preset_q;
  assign load      = load_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign entry_err = entry_err_q;

endmodule

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
// Testbench for keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scans).
module tb_keypad_entry;

  localparam int unsigned ScanCycles = 16;

  logic        gclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  keypadc;
  logic [3:0]  keypadr;
  logic [15:0] preset;
  logic        load, key_valid, entry_err;
  logic [3:0]  key_code;

  logic [11:0] pressed = '0;   // physical key matrix, bit = row*3 + col

  int passed = 0;
  int total  = 0;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .gclk      (gclk),
    .rst_n     (rst_n),
    .keypadc   (keypadc),
    .keypadr   (keypadr),
    .preset    (preset),
    .load      (load),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry_err (entry_err)
  );

  always #5 gclk = ~gclk;

  // Closed switches connect the driven row to their column.
  always_comb begin
    keypadc = '0;
    for (int r = 0; r < 4; r++) if (keypadr[r]) keypadc = keypadc | pressed[r*3 +: 3];
  end

  // Pulse monitor.
  int         kv_cnt = 0, ld_cnt = 0, er_cnt = 0;
  logic [3:0] kcodes[$];
  logic       prev_pulse = 1'b0;

  always @(negedge gclk) begin
    if (key_valid) begin
      kv_cnt++;
      kcodes.push_back(key_code);
    end
    if (load) ld_cnt++;
    if (entry_err) er_cnt++;
    if (key_valid || load || entry_err) begin
      total++;
      if (prev_pulse) $display("FAIL pulse_spacing: pulse in consecutive cycles at %0t", $time);
      else passed++;
    end
    prev_pulse = key_valid || load || entry_err;
  end

  // Reference model: the digits typed since the last clear, newest last, at most 4 kept.
  int m_dig[$];

  function automatic logic [15:0] m_value();
    logic [15:0] v = '0;
    foreach (m_dig[i]) v = v * 16 + 16'(m_dig[i]);
    return v;
  endfunction

  function automatic int bit_of(input int code);
    if (code == 0)  return 10;
    if (code == 10) return 9;
    if (code == 11) return 11;
    return code - 1;
  endfunction

  task automatic wait_scans(input int n);
    repeat (n * ScanCycles) @(negedge gclk);
  endtask

  // Press one key for hold scans, release for rel scans, and check against the model.
  task automatic press_check(input int code, input int hold, input int rel);
    int kb = kv_cnt, lb = ld_cnt, eb = er_cnt;
    int exp_ld = 0, exp_er = 0;
    int m10, s10;
    pressed = 12'b1 << bit_of(code);
    wait_scans(hold);
    pressed = '0;
    wait_scans(rel);
    if (code <= 9) begin
      m_dig.push_back(code);
      if (m_dig.size() > 4) void'(m_dig.pop_front());
    end else if (code == 10) begin
      m_dig.delete();
    end else begin
      m10 = (m_dig.size() == 4) ? m_dig[0] : 0;
      s10 = (m_dig.size() >= 2) ? m_dig[m_dig.size()-2] : 0;
      if (m10 <= 5 && s10 <= 5) exp_ld = 1; else exp_er = 1;
    end
    total++;
    if (kv_cnt - kb !== 1) $display("FAIL key_valid_count key=%0d: got %0d want 1", code, kv_cnt - kb);
    else passed++;
    total++;
    if (key_code !== 4'(code)) $display("FAIL key_code: got %h want %h", key_code, 4'(code));
    else passed++;
    total++;
    if (kcodes.size() == 0 || kcodes[kcodes.size()-1] !== 4'(code))
      $display("FAIL pulse_code key=%0d: queue size %0d", code, kcodes.size());
    else passed++;
    total++;
    if (ld_cnt - lb !== exp_ld) $display("FAIL load_count key=%0d: got %0d want %0d", code, ld_cnt - lb, exp_ld);
    else passed++;
    total++;
    if (er_cnt - eb !== exp_er) $display("FAIL err_count key=%0d: got %0d want %0d", code, er_cnt - eb, exp_er);
    else passed++;
    total++;
    if (preset !== m_value()) $display("FAIL preset key=%0d: got %h want %h", code, preset, m_value());
    else passed++;
  endtask

  task automatic test_reset();
    logic [3:0] exp_r;
    rst_n = 1'b0;
    pressed = '0;
    repeat (3) @(negedge gclk);
    total++;
    if ({keypadr, preset, load, key_valid, entry_err, key_code} !== {4'b0001, 16'h0, 3'b0, 4'h0})
      $display("FAIL reset_values: got r=%b p=%h l=%b v=%b e=%b c=%h want r=0001 p=0000 0 0 0 c=0",
               keypadr, preset, load, key_valid, entry_err, key_code);
    else passed++;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_r = 4'b0001 << ((k / 4) % 4);
      total++;
      if ({keypadr, preset, load, key_valid, entry_err} !== {exp_r, 16'h0, 3'b0})
        $display("FAIL row_scan k=%0d: got r=%b p=%h pulses=%b want r=%b", k, keypadr, preset,
                 {load, key_valid, entry_err}, exp_r);
      else passed++;
      @(negedge gclk);
    end
    m_dig.delete();
  endtask

  task automatic test_entry();
    press_check(1, 3, 3);
    press_check(2, 3, 3);
    press_check(3, 3, 3);
    press_check(0, 3, 3);
    total++;
    if (preset !== 16'h1230) $display("FAIL entry_preset: got %h want 1230", preset);
    else passed++;
    press_check(11, 3, 3);
    total++;
    if (preset !== 16'h1230) $display("FAIL hash_hold: got %h want 1230", preset);
    else passed++;
  endtask

  task automatic test_shift_clear();
    for (int d = 1; d <= 5; d++) press_check(d, 3, 3);
    press_check(11, 3, 3);
    total++;
    if (preset !== 16'h2345) $display("FAIL shift_preset: got %h want 2345", preset);
    else passed++;
    press_check(10, 3, 3);
    total++;
    if ({preset, key_code} !== {16'h0000, 4'hA}) $display("FAIL star_clear: got %h/%h want 0000/a", preset, key_code);
    else passed++;
  endtask

  task automatic test_entry_err();
    int eb;
    press_check(0, 3, 3);
    press_check(1, 3, 3);
    press_check(7, 3, 3);
    press_check(0, 3, 3);
    eb = er_cnt;
    press_check(11, 3, 3);
    total++;
    if ({preset, 1'(er_cnt - eb == 1)} !== {16'h0170, 1'b1})
      $display("FAIL err_case: got preset %h errs %0d want 0170 and 1", preset, er_cnt - eb);
    else passed++;
  endtask

  task automatic test_glitch_multi();
    int kb = kv_cnt;
    logic [15:0] p0 = preset;
    pressed = 12'b1 << bit_of(5);
    repeat (ScanCycles) @(negedge gclk);
    pressed = '0;
    wait_scans(3);
    pressed = (12'b1 << bit_of(5)) | (12'b1 << bit_of(6));
    wait_scans(5);
    pressed = '0;
    wait_scans(3);
    total++;
    if ({kv_cnt - kb, preset} !== {32'd0, p0})
      $display("FAIL glitch_multi: got %0d events preset %h want 0 events preset %h", kv_cnt - kb, preset, p0);
    else passed++;
    press_check(4, 10, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++)
      press_check(int'($urandom_range(0, 11)), int'($urandom_range(3, 5)), int'($urandom_range(3, 4)));
  endtask

  task automatic test_mid_reset();
    int kb;
    pressed = 12'b1 << bit_of(9);
    repeat (37) @(negedge gclk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({keypadr, preset, load, key_valid, entry_err, key_code} !== {4'b0001, 16'h0, 3'b0, 4'h0})
      $display("FAIL mid_reset_values: got r=%b p=%h pulses=%b c=%h want 0001/0000/000/0",
               keypadr, preset, {load, key_valid, entry_err}, key_code);
    else passed++;
    repeat (2) @(negedge gclk);
    m_dig.delete();
    kb = kv_cnt;
    rst_n = 1'b1;
    press_check(9, 4, 3);
    total++;
    if ({kv_cnt - kb, preset} !== {32'd1, 16'h0009})
      $display("FAIL held_through_reset: got %0d events preset %h want 1 and 0009", kv_cnt - kb, preset);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_entry();
    test_shift_clear();
    test_entry_err();
    test_glitch_multi();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
